// File: rtl/ublock_key_pkg.sv
// uBlock key-schedule constants, FSM encoding and helpers.
// Shared by the round sequencer and the masked S-box array.
package ublock_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
    4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5
  };

  localparam logic [31:0] RC [16] = '{
    32'h988cc9dd, 32'hf0e4a1b5, 32'h21357064, 32'h8185d0c4,
    32'hc0c59104, 32'h4144d1c5, 32'h4242d2c6, 32'h4747d7c3,
    32'h4d4dddc9, 32'h5959c9dd, 32'h7171e1f5, 32'h2121b1a5,
    32'h8181113d, 32'hc1c1518d, 32'h41403efd, 32'h4343fccf
  };

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input int          n
  );
    logic [4:0] s;
    s = 5'(n);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [31:0] sbox32(
    input logic [31:0] x
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = SBOX[x[4*i +: 4]];
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_sbox_array_for_key.sv
// 2-share 32-bit S-box array, two register stages.
// Ports: in0_i/in1_i shares in, out0_o/out1_o shares out.
module shared_sbox_array_for_key
  import ublock_key_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in0_i,
  input  logic [31:0] in1_i,
  output logic [31:0] out0_o,
  output logic [31:0] out1_o
);

  logic [31:0] a0_q, a1_q;
  logic [31:0] o0_q, o1_q;

  // Masked table lookup: share 1 is carried through
  // unchanged and acts as the output mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0;
      a1_q <= '0;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      a0_q <= in0_i;
      a1_q <= in1_i;
      o0_q <= sbox32(a0_q ^ a1_q) ^ a1_q;
      o1_q <= a1_q;
    end
  end

  assign out0_o = o0_q;
  assign out1_o = o1_q;

endmodule

// File: rtl/shared_key_sbox_driver.sv
// Masked key-schedule round sequencer around an external S-box array.
// Ports: start/key_in0/1 in, sbox_array_* link, key_out0/1 + status out.
module shared_key_sbox_driver
  import ublock_key_pkg::*;
#(
  parameter int SBOX_LAT = 2,
  parameter int ROUNDS   = 16,
  parameter int ROT      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] key_in0,
  input  logic [31:0] key_in1,
  output logic [31:0] sbox_array_input0,
  output logic [31:0] sbox_array_input1,
  input  logic [31:0] sbox_array_output0,
  input  logic [31:0] sbox_array_output1,
  output logic [31:0] key_out0,
  output logic [31:0] key_out1,
  output logic        key_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  if (ROUNDS < 0 || ROUNDS > 16) begin : g_rounds_chk
    $error("ROUNDS must be in 0..16");
  end

  localparam int CW =
    (SBOX_LAT < 1) ? 1 : $clog2(SBOX_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(SBOX_LAT);
  localparam logic [3:0] LAST =
    (ROUNDS > 0) ? 4'(ROUNDS - 1) : 4'd0;

  state_e        state_q;
  logic [31:0]   word0_q, word1_q;
  logic [31:0]   key0_q, key1_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    round_q, idx_q;
  logic          kv_q, busy_q, done_q;

  logic [31:0]   word0_d, word1_d;

  // Linear layer stays share-wise; constant on share 0.
  assign word0_d =
    rotl32(sbox_array_output0, ROT) ^ RC[round_q];
  assign word1_d = rotl32(sbox_array_output1, ROT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word0_q <= '0;
      word1_q <= '0;
      key0_q  <= '0;
      key1_q  <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      idx_q   <= '0;
      kv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      kv_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (ROUNDS > 0) begin
              word0_q <= key_in0;
              word1_q <= key_in1;
              cnt_q   <= '0;
              round_q <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != LAT) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            word0_q <= word0_d;
            word1_q <= word1_d;
            key0_q  <= word0_d;
            key1_q  <= word1_d;
            kv_q    <= 1'b1;
            idx_q   <= round_q;
            if (round_q == LAST) begin
              state_q <= ST_DONE;
            end else begin
              round_q <= round_q + 4'd1;
              cnt_q   <= '0;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sbox_array_input0 = word0_q;
  assign sbox_array_input1 = word1_q;
  assign key_out0  = key0_q;
  assign key_out1  = key1_q;
  assign key_valid = kv_q;
  assign round_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shared_key_sbox_driver.sv
// Bench for the masked key-schedule sequencer and its S-box array.
// Checks unmasked key stream against an arithmetic reference.
module tb_shared_key_sbox_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start0;
  logic [31:0] key_in0, key_in1;
  logic [31:0] ai0, ai1, ao0, ao1;
  logic [31:0] key_out0, key_out1;
  logic        key_valid, busy, done;
  logic [3:0]  round_idx;

  logic [31:0] z_ai0, z_ai1, z_k0, z_k1;
  logic        z_kv, z_busy, z_done;
  logic [3:0]  z_idx;

  int tests  = 0;
  int failed = 0;

  logic [31:0] first_u, first_s0, s0_a5;

  localparam logic [3:0] SB [16] = '{
    4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
    4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5
  };

  localparam logic [31:0] RCT [16] = '{
    32'h988cc9dd, 32'hf0e4a1b5, 32'h21357064, 32'h8185d0c4,
    32'hc0c59104, 32'h4144d1c5, 32'h4242d2c6, 32'h4747d7c3,
    32'h4d4dddc9, 32'h5959c9dd, 32'h7171e1f5, 32'h2121b1a5,
    32'h8181113d, 32'hc1c1518d, 32'h41403efd, 32'h4343fccf
  };

  always #5 clk = ~clk;

  shared_key_sbox_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .key_in0(key_in0), .key_in1(key_in1),
    .sbox_array_input0(ai0), .sbox_array_input1(ai1),
    .sbox_array_output0(ao0), .sbox_array_output1(ao1),
    .key_out0(key_out0), .key_out1(key_out1),
    .key_valid(key_valid), .round_idx(round_idx),
    .busy(busy), .done(done)
  );

  shared_sbox_array_for_key arr (
    .clk(clk), .rst(rst),
    .in0_i(ai0), .in1_i(ai1),
    .out0_o(ao0), .out1_o(ao1)
  );

  shared_key_sbox_driver #(.ROUNDS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .key_in0(key_in0), .key_in1(key_in1),
    .sbox_array_input0(z_ai0), .sbox_array_input1(z_ai1),
    .sbox_array_output0(32'h0), .sbox_array_output1(32'h0),
    .key_out0(z_k0), .key_out1(z_k1),
    .key_valid(z_kv), .round_idx(z_idx),
    .busy(z_busy), .done(z_done)
  );

  function automatic logic [31:0] sref(input logic [31:0] u);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = SB[u[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] k0,
                     input logic [31:0] k1,
                     input bit          inject,
                     input int          abort_at);
    logic [31:0] mdl [16];
    logic [31:0] u;
    int n, cyc, lastv, bad;
    bit fin;
    u = k0 ^ k1;
    for (int r = 0; r < 16; r++) begin
      u = rotl8(sref(u)) ^ RCT[r];
      mdl[r] = u;
    end
    key_in0 = k0;
    key_in1 = k1;
    start = 1'b1;
    step();
    start = 1'b0;
    key_in0 = $urandom;
    key_in1 = $urandom;
    cyc = 1; n = 0; lastv = 0; fin = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!fin && cyc < 80) begin
      if (key_valid) begin
        chk("kv_cadence", 32'(cyc), 32'(4 + 3 * n));
        chk("round_idx", 32'(round_idx), 32'(n));
        if (n < 16)
          chk("unmasked_key", key_out0 ^ key_out1, mdl[n]);
        if (n == 0) begin
          first_u  = key_out0 ^ key_out1;
          first_s0 = key_out0;
        end
        n++;
        lastv = cyc;
      end
      if (done) begin
        chk("kv_count", 32'(n), 32'd16);
        chk("done_timing", 32'(cyc), 32'(lastv + 1));
        fin = 1'b1;
      end
      if (abort_at >= 0 && n == abort_at + 1 &&
          cyc == lastv + 1) begin
        rst = 1'b1;
        #1;
        chk("abort_key0", key_out0, 32'h0);
        chk("abort_key1", key_out1, 32'h0);
        chk("abort_idx", 32'(round_idx), 32'h0);
        chk("abort_flags", {29'h0, key_valid, busy, done}, 32'h0);
        chk("abort_arr_in", ai0 | ai1, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
          if (key_valid || busy || done) bad++;
          step();
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        return;
      end
      start = (inject && (cyc == 5 || cyc == 9));
      step();
      start = 1'b0;
      cyc++;
    end
    chk("run_finished", 32'(fin), 32'd1);
    step();
    chk("post_busy_done", {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    int dcyc, kvs, bsy;
    rst = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    key_in0 = '0;
    key_in1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key0", key_out0, 32'h0);
    chk("rst_key1", key_out1, 32'h0);
    chk("rst_idx", 32'(round_idx), 32'h0);
    chk("rst_flags", {29'h0, key_valid, busy, done}, 32'h0);
    chk("rst_arr_in", ai0 | ai1, 32'h0);
    rst = 1'b0;
    step();

    run(32'h0, 32'h0, 1'b0, -1);
    chk("zero_key_r0", first_u, 32'h77777777 ^ RCT[0]);

    run(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, -1);
    s0_a5 = first_s0;
    run(32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, -1);
    chk("shares_differ", 32'(s0_a5 != first_s0), 32'd1);

    for (int i = 0; i < 3; i++)
      run($urandom, $urandom, 1'b0, -1);

    run($urandom, $urandom, 1'b1, -1);

    run($urandom, $urandom, 1'b0, 6);
    run($urandom, $urandom, 1'b0, -1);

    start0 = 1'b1;
    step();
    start0 = 1'b0;
    dcyc = 0; kvs = 0; bsy = 0;
    for (int c = 1; c <= 6; c++) begin
      if (z_done && dcyc == 0) dcyc = c;
      if (z_kv) kvs++;
      if (z_busy) bsy++;
      step();
    end
    chk("r0_done_cycle", 32'(dcyc), 32'd2);
    chk("r0_no_kv", 32'(kvs), 32'd0);
    chk("r0_no_busy", 32'(bsy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
